// File: rtl/minc_pkg.sv
// Shared types and constants for the minc stack core and its program loader.
package minc_pkg;

  localparam int INSTR_W = 11;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    OP_LD   = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_HALT = 3'd4
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } ld_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_BAD_HI  = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  // Only the low three bits of a HI byte carry the opcode; the rest must be clear.
  function automatic logic hi_byte_ok(input logic [7:0] b);
    return (b[7:3] == 5'd0);
  endfunction

endpackage

// File: rtl/minc_loader.sv
// Framed program-image loader: writes instruction memory and releases the core on a valid image.
// Optional macro MINC_LOADER_TIMEOUT_EN adds an inter-byte idle timeout inside a frame.
module minc_loader
  import minc_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
`ifdef MINC_LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_nreset,
  output logic               done,
  output logic               error,
  output err_code_t          err_code
);

  ld_state_t          r_state;
  ld_state_t          w_state_nxt;
  logic [7:0]         r_n;
  logic [7:0]         r_cnt;
  logic [7:0]         r_acc;
  logic [2:0]         r_opcode;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [INSTR_W-1:0] r_wr_data;
  logic               r_cpu_nreset;
  logic               r_done;
  logic               r_error;
  err_code_t          r_err_code;

  logic       w_xfer;
  logic       w_last;
  logic [7:0] w_sum;
  logic       w_timeout;
  logic       w_ld_n;
  logic       w_ld_hi;
  logic       w_ld_lo;
  logic       w_set_done;
  logic       w_set_err;
  logic       w_clr;
  err_code_t  w_err_code_nxt;

  assign rx_ready = 1'b1;
  assign w_xfer   = rx_valid;
  // N=0 encodes 256 words, so N-1 wraps to 255 and the same compare covers it.
  assign w_last   = (r_cnt == (r_n - 8'd1));
  assign w_sum    = r_acc + rx_data;

`ifdef MINC_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;
  logic              w_in_frame;

  assign w_in_frame = (r_state == ST_COUNT) || (r_state == ST_HI) ||
                      (r_state == ST_LO)    || (r_state == ST_CSUM);
  assign w_timeout  = w_in_frame && !w_xfer && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, cleared by any transfer or outside a frame.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_idle <= '0;
    end else if (w_xfer || !w_in_frame) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_n         = 1'b0;
    w_ld_hi        = 1'b0;
    w_ld_lo        = 1'b0;
    w_set_done     = 1'b0;
    w_set_err      = 1'b0;
    w_clr          = 1'b0;
    w_err_code_nxt = ERR_NONE;
    if (w_timeout) begin
      w_state_nxt    = ST_ERR;
      w_set_err      = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && (rx_data == SYNC_BYTE)) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (w_xfer) begin
            w_ld_n      = 1'b1;
            w_state_nxt = ST_HI;
          end else begin
            w_state_nxt = ST_COUNT;
          end
        end
        ST_HI: begin
          if (w_xfer && !hi_byte_ok(rx_data)) begin
            w_state_nxt    = ST_ERR;
            w_set_err      = 1'b1;
            w_err_code_nxt = ERR_BAD_HI;
          end else if (w_xfer) begin
            w_ld_hi     = 1'b1;
            w_state_nxt = ST_LO;
          end else begin
            w_state_nxt = ST_HI;
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            w_ld_lo     = 1'b1;
            w_state_nxt = w_last ? ST_CSUM : ST_HI;
          end else begin
            w_state_nxt = ST_LO;
          end
        end
        ST_CSUM: begin
          if (w_xfer && (w_sum == 8'd0)) begin
            w_state_nxt = ST_DONE;
            w_set_done  = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt    = ST_ERR;
            w_set_err      = 1'b1;
            w_err_code_nxt = ERR_CSUM;
          end else begin
            w_state_nxt = ST_CSUM;
          end
        end
        ST_DONE, ST_ERR: begin
          if (w_xfer && (rx_data == SYNC_BYTE)) begin
            w_state_nxt = ST_COUNT;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Frame datapath, write port and status registers.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_n          <= 8'd0;
      r_cnt        <= 8'd0;
      r_acc        <= 8'd0;
      r_opcode     <= 3'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_nreset <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_wr_en <= w_ld_lo;
      if (w_ld_n) begin
        r_n   <= rx_data;
        r_cnt <= 8'd0;
        r_acc <= rx_data;
      end
      if (w_ld_hi) begin
        r_opcode <= rx_data[2:0];
        r_acc    <= w_sum;
      end
      if (w_ld_lo) begin
        r_acc     <= w_sum;
        r_wr_addr <= r_cnt;
        r_wr_data <= {r_opcode, rx_data};
        r_cnt     <= r_cnt + 8'd1;
      end
      if (w_set_done) begin
        r_done       <= 1'b1;
        r_cpu_nreset <= 1'b1;
      end else if (w_set_err) begin
        r_error      <= 1'b1;
        r_err_code   <= w_err_code_nxt;
        r_cpu_nreset <= 1'b0;
      end else if (w_clr) begin
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_err_code   <= ERR_NONE;
        r_cpu_nreset <= 1'b0;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_nreset = r_cpu_nreset;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_minc_loader.sv
// Scoreboard bench for minc_loader: expected writes are queued by the driver and checked by a monitor.
module tb_minc_loader;
  import minc_pkg::*;

  logic               CLK;
  logic               nRESET;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               cpu_nreset;
  logic               done;
  logic               error;
  err_code_t          err_code;

`ifdef MINC_LOADER_TIMEOUT_EN
  minc_loader #(.TIMEOUT_CYCLES(16)) dut (
`else
  minc_loader dut (
`endif
    .CLK(CLK), .nRESET(nRESET), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_nreset(cpu_nreset), .done(done), .error(error), .err_code(err_code)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [10:0] data;
    int          cyc;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every observed write must match the oldest queued expectation, in the expected cycle.
  always @(negedge CLK) begin
    if (wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", wr_addr, wr_data);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          n_errors++;
          $display("FAIL write: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  // Send a LO byte and expect the write to appear in the cycle right after its transfer edge.
  task automatic send_lo(input logic [7:0] b, input logic [7:0] addr, input logic [10:0] data);
    wr_exp_t e;
    send(b);
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic status(input string tag, input logic d, input logic er, input logic [1:0] code,
                        input logic cpu);
    @(negedge CLK);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, er});
    check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
    check({tag, "_cpu_nreset"}, {31'd0, cpu_nreset}, {31'd0, cpu});
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {21'd0, wr_data}, 32'd0);
    check({tag, "_cpu_nreset"}, {31'd0, cpu_nreset}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRESET   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset_outputs("reset");
    nRESET = 1'b1;

    // Good two-word load.
    send(8'hA5); send(8'h02);
    send(8'h00); send_lo(8'h05, 8'd0, 11'h005);
    send(8'h01); send_lo(8'h00, 8'd1, 11'h100);
    send(8'hF8);
    status("good", 1'b1, 1'b0, 2'd0, 1'b1);

    // Reload from DONE: core goes back into reset, then checksum mismatch.
    send(8'hA5);
    status("reload", 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'h02);
    send(8'h00); send_lo(8'h05, 8'd0, 11'h005);
    send(8'h01); send_lo(8'h00, 8'd1, 11'h100);
    send(8'hF7);
    status("badsum", 1'b0, 1'b1, 2'd2, 1'b0);

    // Bad high byte, garbage while in ERR, then recovery with a HALT word.
    send(8'hA5);
    status("err_exit", 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'h01); send(8'h08);
    status("badhi", 1'b0, 1'b1, 2'd1, 1'b0);
    send(8'h00); send(8'h33);
    status("err_hold", 1'b0, 1'b1, 2'd1, 1'b0);
    send(8'hA5); send(8'h01);
    send(8'h04); send_lo(8'h07, 8'd0, 11'h407);
    send(8'hF4);
    status("recover", 1'b1, 1'b0, 2'd0, 1'b1);

    // Full 256-word image, N=0.
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h00);
      send_lo(i[7:0], i[7:0], {3'd0, i[7:0]});
    end
    send(8'h80);
    status("full", 1'b1, 1'b0, 2'd0, 1'b1);

    // Reset arriving on the same edge as a LO byte: no write may appear.
    send(8'hA5); send(8'h01); send(8'h02);
    @(negedge CLK);
    rx_data  = 8'h03;
    rx_valid = 1'b1;
    nRESET   = 1'b0;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    @(negedge CLK);
    reset_outputs("midreset");
    nRESET = 1'b1;
    send(8'h01); send(8'h02); send(8'h11); send(8'hA5 ^ 8'hFF);
    status("garbage", 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'hA5); send(8'h01);
    send(8'h01); send_lo(8'h22, 8'd0, 11'h122);
    send(8'hDC);
    status("after_reset", 1'b1, 1'b0, 2'd0, 1'b1);

    // Idle inside a frame.
    send(8'hA5); send(8'h01);
`ifdef MINC_LOADER_TIMEOUT_EN
    repeat (15) @(posedge CLK);
    status("idle15", 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge CLK);
    status("timeout", 1'b0, 1'b1, 2'd3, 1'b0);
    send(8'hA5); send(8'h01);
`else
    repeat (1000) @(posedge CLK);
    status("idle1000", 1'b0, 1'b0, 2'd0, 1'b0);
`endif
    send(8'h00); send_lo(8'h09, 8'd0, 11'h009);
    send(8'hF6);
    status("idle_resume", 1'b1, 1'b0, 2'd0, 1'b1);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
